// File: rtl/prover_compute_v_folded_pkg.sv
// Shared field definitions and fold-FSM encodings for the folded V-table prover.
// Field is F_q with q = 65521, the largest 16-bit prime.
package prover_compute_v_folded_pkg;

   localparam int                 F_NBITS = 16;
   localparam logic [F_NBITS-1:0] F_Q     = 16'd65521;

   typedef logic [F_NBITS-1:0] fe_t;

   typedef logic [1:0] fold_st_t;
   localparam fold_st_t ST_IDLE   = 2'd0;
   localparam fold_st_t ST_ISSUE  = 2'd1;
   localparam fold_st_t ST_DRAIN  = 2'd2;
   localparam fold_st_t ST_COMMIT = 2'd3;

   // Operands must already be reduced; one conditional subtract suffices.
   function automatic fe_t f_add(input fe_t a, input fe_t b);
      logic [F_NBITS:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, F_Q}) s = s - {1'b0, F_Q};
      return s[F_NBITS-1:0];
   endfunction

   // a - b taken as a + (q - b); q - 0 = q is still absorbed by f_add.
   function automatic fe_t f_sub(input fe_t a, input fe_t b);
      return f_add(a, F_Q - b);
   endfunction

   function automatic fe_t f_mul(input fe_t a, input fe_t b);
      logic [2*F_NBITS-1:0] p;
      logic [2*F_NBITS-1:0] r;
      p = {{F_NBITS{1'b0}}, a} * {{F_NBITS{1'b0}}, b};
      r = p % {{F_NBITS{1'b0}}, F_Q};
      return r[F_NBITS-1:0];
   endfunction

endpackage

// File: rtl/prover_fold_lane.sv
// One fold lane: res = a + tau*(b - a) mod q, delivered MUL_LAT cycles after i_vld.
// i_flush empties the valid pipeline so in-flight work from an aborted round vanishes.
module prover_fold_lane
   import prover_compute_v_folded_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic clk,
   input  logic rstb,
   input  logic i_flush,
   input  logic i_vld,
   input  fe_t  i_a,
   input  fe_t  i_b,
   input  fe_t  i_tau,
   output logic o_vld,
   output fe_t  o_res
);

   fe_t                             w_res;
   logic [MUL_LAT:1]                r_vld_pipe;
   logic [MUL_LAT:1][F_NBITS-1:0]   r_res_pipe;

   assign w_res = f_add(i_a, f_mul(i_tau, f_sub(i_b, i_a)));

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_vld_pipe <= '0;
         r_res_pipe <= '0;
      end else begin
         r_res_pipe[1] <= w_res;
         for (int k = 2; k <= MUL_LAT; k++) r_res_pipe[k] <= r_res_pipe[k-1];
         if (i_flush) begin
            r_vld_pipe <= '0;
         end else begin
            r_vld_pipe[1] <= i_vld;
            for (int k = 2; k <= MUL_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
         end
      end
   end

   assign o_vld = r_vld_pipe[MUL_LAT];
   assign o_res = r_res_pipe[MUL_LAT];

endmodule

// File: rtl/prover_compute_v_folded.sv
// Sum-check V-table evaluator: holds the gate table and folds it in place each round
// with NMUL time-multiplexed lanes; restart+en aborts any round in progress.
module prover_compute_v_folded
   import prover_compute_v_folded_pkg::*;
#(
   parameter  int NGATES  = 43,
   parameter  int NMUL    = 4,
   parameter  int MUL_LAT = 3,
   localparam int N0      = 1 << $clog2(NGATES),
   localparam int NOUT    = N0 / 2,
   localparam int NROUNDS = $clog2(N0),
   localparam int RW      = $clog2(NROUNDS + 1)
) (
   input  logic                           clk,
   input  logic                           rstb,
   input  logic                           en,
   input  logic                           restart,
   input  logic [NGATES-1:0][F_NBITS-1:0] v_in,
   input  logic [F_NBITS-1:0]             tau,
   output logic                           ready,
   output logic                           ready_pulse,
   output logic [NOUT-1:0][F_NBITS-1:0]   v_0,
   output logic [NOUT-1:0][F_NBITS-1:0]   v_1,
   output logic [NOUT-1:0][F_NBITS-1:0]   v_tau,
   output logic [RW-1:0]                  round,
   output logic                           last_round,
   output logic [F_NBITS-1:0]             v_final
);

   localparam int BW = $clog2(NOUT + 1);
   localparam int DW = $clog2(MUL_LAT + 2);

   fold_st_t                        r_state;
   logic [N0-1:0][F_NBITS-1:0]      r_table;
   logic [N0-1:0][F_NBITS-1:0]      w_vin_pad;
   logic [NOUT-1:0][F_NBITS-1:0]    r_shadow;
   logic [NOUT-1:0][F_NBITS-1:0]    r_vtau;
   logic [RW-1:0]                   r_round;
   logic [F_NBITS-1:0]              r_tau;
   logic [BW-1:0]                   r_beat;
   logic [BW-1:0]                   r_lane_beat;
   logic [DW-1:0]                   r_drain;
   logic                            r_lane_vld;
   logic                            r_pulse;
   logic [NMUL-1:0][F_NBITS-1:0]    r_lane_a;
   logic [NMUL-1:0][F_NBITS-1:0]    r_lane_b;
   logic [NMUL-1:0][F_NBITS-1:0]    w_mux_a;
   logic [NMUL-1:0][F_NBITS-1:0]    w_mux_b;
   logic [NMUL-1:0][F_NBITS-1:0]    w_res;
   logic [NMUL-1:0]                 w_res_vld;
   logic [MUL_LAT:1][BW-1:0]        r_idx_pipe;
   logic                            w_accept;
   logic                            w_ready;
   logic                            w_last;
   int                              w_half;
   int                              w_nbeats;

   for (genvar g = 0; g < N0; g++) begin : g_pad
      if (g < NGATES) begin : g_in
         assign w_vin_pad[g] = v_in[g];
      end else begin : g_zero
         assign w_vin_pad[g] = '0;
      end
   end

   // Live pair count of the current table; 0 once fully folded.
   always_comb begin
      w_half   = N0 >> (int'(r_round) + 1);
      w_nbeats = (w_half + NMUL - 1) / NMUL;
   end

   assign w_ready  = (r_state == ST_IDLE);
   assign w_last   = (r_round == RW'(NROUNDS));
   assign w_accept = en & (restart | (w_ready & ~w_last));

   // Pair p rides lane p%NMUL on beat p/NMUL; unused lanes see zeros.
   always_comb begin
      w_mux_a = '0;
      w_mux_b = '0;
      for (int p = 0; p < NOUT; p++) begin
         if (int'(r_beat) == p / NMUL && p < w_half) begin
            w_mux_a[p % NMUL] = r_table[2*p];
            w_mux_b[p % NMUL] = r_table[2*p+1];
         end
      end
   end

   for (genvar l = 0; l < NMUL; l++) begin : g_lane
      prover_fold_lane #(.MUL_LAT(MUL_LAT)) u_lane (
         .clk     (clk),
         .rstb    (rstb),
         .i_flush (w_accept),
         .i_vld   (r_lane_vld),
         .i_a     (r_lane_a[l]),
         .i_b     (r_lane_b[l]),
         .i_tau   (r_tau),
         .o_vld   (w_res_vld[l]),
         .o_res   (w_res[l])
      );
   end

   // Beat index travels beside the lanes so results land in the right shadow slot.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_idx_pipe <= '0;
         r_shadow   <= '0;
      end else begin
         r_idx_pipe[1] <= r_lane_beat;
         for (int k = 2; k <= MUL_LAT; k++) r_idx_pipe[k] <= r_idx_pipe[k-1];
         for (int p = 0; p < NOUT; p++) begin
            if (w_res_vld[p % NMUL] && int'(r_idx_pipe[MUL_LAT]) == p / NMUL)
               r_shadow[p] <= w_res[p % NMUL];
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_state     <= ST_IDLE;
         r_table     <= '0;
         r_vtau      <= '0;
         r_round     <= '0;
         r_tau       <= '0;
         r_beat      <= '0;
         r_lane_beat <= '0;
         r_drain     <= '0;
         r_lane_vld  <= 1'b0;
         r_pulse     <= 1'b0;
         r_lane_a    <= '0;
         r_lane_b    <= '0;
      end else begin
         r_pulse    <= 1'b0;
         r_lane_vld <= 1'b0;
         if (w_accept) begin
            r_tau   <= tau;
            r_beat  <= '0;
            r_state <= ST_ISSUE;
            if (restart) begin
               r_table <= w_vin_pad;
               r_round <= '0;
            end
         end else begin
            case (r_state)
               ST_ISSUE: begin
                  r_lane_vld  <= 1'b1;
                  r_lane_a    <= w_mux_a;
                  r_lane_b    <= w_mux_b;
                  r_lane_beat <= r_beat;
                  if (int'(r_beat) == w_nbeats - 1) begin
                     r_drain <= '0;
                     r_state <= ST_DRAIN;
                  end else begin
                     r_beat <= r_beat + BW'(1);
                  end
               end
               // One extra cycle covers the lane-input register stage.
               ST_DRAIN: begin
                  if (int'(r_drain) == MUL_LAT) r_state <= ST_COMMIT;
                  else                          r_drain <= r_drain + DW'(1);
               end
               ST_COMMIT: begin
                  r_table <= '0;
                  for (int i = 0; i < NOUT; i++) begin
                     r_vtau[i] <= (i < w_half) ? r_shadow[i] : '0;
                     if (i < w_half) r_table[i] <= r_shadow[i];
                  end
                  r_round <= r_round + RW'(1);
                  r_pulse <= 1'b1;
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   always_comb begin
      v_0 = '0;
      v_1 = '0;
      for (int i = 0; i < NOUT; i++) begin
         if (i < w_half) begin
            v_0[i] = r_table[2*i];
            v_1[i] = r_table[2*i+1];
         end
      end
   end

   assign ready       = w_ready;
   assign ready_pulse = r_pulse;
   assign v_tau       = r_vtau;
   assign round       = r_round;
   assign last_round  = w_last;
   assign v_final     = r_table[0];

endmodule

// File: tb/tb_prover_compute_v_folded.sv
// Directed bench: a 4-gate single-lane instance with hand-computed folds and a
// 43-gate four-lane instance checked round by round against a reference fold.
module tb_prover_compute_v_folded;

   localparam int Q  = 65521;
   localparam int ML = 3;

   logic clk = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // ---------------- instance A: ngates=4, nmul=1
   logic              en_a = 1'b0, restart_a = 1'b0;
   logic [3:0][15:0]  vin_a = '0;
   logic [15:0]       tau_a = '0;
   logic              ready_a, pulse_a, last_a;
   logic [1:0][15:0]  v0_a, v1_a, vt_a;
   logic [1:0]        rnd_a;
   logic [15:0]       vf_a;

   prover_compute_v_folded #(.NGATES(4), .NMUL(1), .MUL_LAT(ML)) u_dut_a (
      .clk(clk), .rstb(rstb), .en(en_a), .restart(restart_a), .v_in(vin_a), .tau(tau_a),
      .ready(ready_a), .ready_pulse(pulse_a), .v_0(v0_a), .v_1(v1_a), .v_tau(vt_a),
      .round(rnd_a), .last_round(last_a), .v_final(vf_a)
   );

   // ---------------- instance B: ngates=43, nmul=4
   logic              en_b = 1'b0, restart_b = 1'b0;
   logic [42:0][15:0] vin_b = '0;
   logic [15:0]       tau_b = '0;
   logic              ready_b, pulse_b, last_b;
   logic [31:0][15:0] v0_b, v1_b, vt_b;
   logic [2:0]        rnd_b;
   logic [15:0]       vf_b;

   prover_compute_v_folded #(.NGATES(43), .NMUL(4), .MUL_LAT(ML)) u_dut_b (
      .clk(clk), .rstb(rstb), .en(en_b), .restart(restart_b), .v_in(vin_b), .tau(tau_b),
      .ready(ready_b), .ready_pulse(pulse_b), .v_0(v0_b), .v_1(v1_b), .v_tau(vt_b),
      .round(rnd_b), .last_round(last_b), .v_final(vf_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Call at #1 after a posedge; v_in is set by the caller. hold_en keeps en (no restart)
   // asserted for that many cycles after the accept to show it is ignored while busy.
   task automatic run_a(input bit rs, input logic [15:0] t, input int exp_cyc,
                        input int hold_en, input string tag);
      int cyc;
      restart_a = rs; tau_a = t; en_a = 1'b1;
      @(posedge clk); #1;
      restart_a = 1'b0; en_a = (hold_en > 0);
      chk({tag, "_busy"}, 32'(ready_a), 32'd0);
      cyc = 0;
      while (!pulse_a && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         en_a = (cyc < hold_en);
      end
      en_a = 1'b0;
      chk({tag, "_lat"}, cyc, exp_cyc);
      chk({tag, "_rdy"}, 32'(ready_a), 32'd1);
      @(posedge clk); #1;
      chk({tag, "_pulse1"}, 32'(pulse_a), 32'd0);
   endtask

   task automatic run_b(input bit rs, input logic [15:0] t, input int exp_cyc, input string tag);
      int cyc;
      restart_b = rs; tau_b = t; en_b = 1'b1;
      @(posedge clk); #1;
      restart_b = 1'b0; en_b = 1'b0;
      chk({tag, "_busy"}, 32'(ready_b), 32'd0);
      cyc = 0;
      while (!pulse_b && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk({tag, "_lat"}, cyc, exp_cyc);
      @(posedge clk); #1;
      chk({tag, "_pulse1"}, 32'(pulse_b), 32'd0);
   endtask

   int          mdl[64];
   int          nxt[64];
   int          taus[6] = '{5, 65520, 777, 3, 12345, 40000};
   int          h;
   int          pulses;
   longint      d;

   initial begin
      // ---------------- reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready_a), 32'd1);
      chk("rst_pulse", 32'(pulse_a), 32'd0);
      chk("rst_round", 32'(rnd_a), 32'd0);
      chk("rst_last", 32'(last_a), 32'd0);
      chk("rst_vtau", vt_a, 32'd0);
      chk("rst_vfinal_b", 32'(vf_b), 32'd0);
      rstb = 1'b1;
      @(posedge clk); #1;

      // ---------------- A: {1,2,3,4}, tau=2 -> {3,5}
      vin_a[0] = 16'd1; vin_a[1] = 16'd2; vin_a[2] = 16'd3; vin_a[3] = 16'd4;
      run_a(1'b1, 16'd2, 7, 0, "a_r1");
      chk("a_r1_vtau", vt_a, 32'h0005_0003);
      chk("a_r1_v0", v0_a, 32'h0000_0003);
      chk("a_r1_v1", v1_a, 32'h0000_0005);
      chk("a_r1_round", 32'(rnd_a), 32'd1);
      chk("a_r1_last", 32'(last_a), 32'd0);

      // continue with tau=3: 3 + 3*(5-3) = 9
      run_a(1'b0, 16'd3, 6, 0, "a_r2");
      chk("a_r2_vtau", vt_a, 32'h0000_0009);
      chk("a_r2_vfinal", 32'(vf_a), 32'd9);
      chk("a_r2_round", 32'(rnd_a), 32'd2);
      chk("a_r2_last", 32'(last_a), 32'd1);

      // en without restart at last_round: ignored
      pulses = 0;
      en_a = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (pulse_a) pulses++;
         if (!ready_a) pulses += 100;
      end
      en_a = 1'b0;
      chk("a_last_en_ign", pulses, 0);
      chk("a_last_round", 32'(rnd_a), 32'd2);

      // tau=0 gives even entries; en held while busy must not disturb the round
      run_a(1'b1, 16'd0, 7, 3, "a_tau0");
      chk("a_tau0_vtau", vt_a, 32'h0003_0001);
      run_a(1'b1, 16'd1, 7, 0, "a_tau1");
      chk("a_tau1_vtau", vt_a, 32'h0004_0002);

      // subtraction wrap: v_0=q-1, v_1=0
      vin_a[0] = 16'(Q - 1); vin_a[1] = 16'd0; vin_a[2] = 16'd5; vin_a[3] = 16'd7;
      run_a(1'b1, 16'd1, 7, 0, "a_wrap1");
      chk("a_wrap1_vtau", vt_a, 32'h0007_0000);
      run_a(1'b1, 16'd2, 7, 0, "a_wrap2");
      chk("a_wrap2_vtau", vt_a, 32'h0009_0001);

      // restart alone has no effect
      restart_a = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      restart_a = 1'b0;
      chk("a_rs_alone_rdy", 32'(ready_a), 32'd1);
      chk("a_rs_alone_round", 32'(rnd_a), 32'd1);
      chk("a_rs_alone_vtau", vt_a, 32'h0009_0001);

      // abort mid-ISSUE: old round must never pulse
      vin_a[0] = 16'd1; vin_a[1] = 16'd2; vin_a[2] = 16'd3; vin_a[3] = 16'd4;
      restart_a = 1'b1; en_a = 1'b1; tau_a = 16'd2;
      @(posedge clk); #1;
      vin_a[0] = 16'd10; vin_a[1] = 16'd20; vin_a[2] = 16'd30; vin_a[3] = 16'd40;
      run_a(1'b1, 16'd1, 7, 0, "a_abort");
      chk("a_abort_vtau", vt_a, 32'h0028_0014);
      chk("a_abort_round", 32'(rnd_a), 32'd1);

      // ---------------- B: 43 gates zero-padded to 64, six rounds
      for (int i = 0; i < 64; i++) mdl[i] = (i < 43) ? (i * 1237 + 11) % Q : 0;
      for (int i = 0; i < 43; i++) vin_b[i] = 16'(mdl[i]);
      for (int r = 0; r < 6; r++) begin
         h = 32 >> r;
         for (int i = 0; i < 64; i++) nxt[i] = 0;
         for (int i = 0; i < h; i++) begin
            d = longint'(mdl[2*i+1] + Q - mdl[2*i]) % Q;
            nxt[i] = int'((longint'(mdl[2*i]) + longint'(taus[r]) * d) % Q);
         end
         for (int i = 0; i < 64; i++) mdl[i] = nxt[i];
         run_b(r == 0, 16'(taus[r]), (h + 3) / 4 + ML + 2, $sformatf("b_r%0d", r + 1));
         for (int i = 0; i < 32; i++)
            chk($sformatf("b_r%0d_vt%0d", r + 1, i), 32'(vt_b[i]), 32'(mdl[i]));
         chk($sformatf("b_r%0d_round", r + 1), 32'(rnd_b), 32'(r + 1));
         if (h > 1) begin
            chk($sformatf("b_r%0d_v0", r + 1), 32'(v0_b[0]), 32'(mdl[0]));
            chk($sformatf("b_r%0d_v1", r + 1), 32'(v1_b[0]), 32'(mdl[1]));
         end
      end
      chk("b_vfinal", 32'(vf_b), 32'(mdl[0]));
      chk("b_last", 32'(last_b), 32'd1);

      // ---------------- async reset mid-DRAIN
      vin_a[0] = 16'd1; vin_a[1] = 16'd2; vin_a[2] = 16'd3; vin_a[3] = 16'd4;
      restart_a = 1'b1; en_a = 1'b1; tau_a = 16'd2;
      @(posedge clk); #1;
      restart_a = 1'b0; en_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("a_drain_busy", 32'(ready_a), 32'd0);
      rstb = 1'b0;
      #1;
      chk("a_rst_ready", 32'(ready_a), 32'd1);
      chk("a_rst_round", 32'(rnd_a), 32'd0);
      chk("a_rst_vtau", vt_a, 32'd0);
      chk("a_rst_v0", v0_a, 32'd0);
      chk("a_rst_v1", v1_a, 32'd0);
      chk("a_rst_vfinal", 32'(vf_a), 32'd0);
      chk("b_rst_vfinal", 32'(vf_b), 32'd0);
      #2;
      rstb = 1'b1;
      @(posedge clk); #1;
      chk("a_post_rst_pulse", 32'(pulse_a), 32'd0);
      run_a(1'b1, 16'd2, 7, 0, "a_post");
      chk("a_post_vtau", vt_a, 32'h0005_0003);
      chk("a_post_round", 32'(rnd_a), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
